// File: rtl/ctrl_encode_def.sv
// Shared encodings for the MIPS control path: ALU opcodes, op/funct fields,
// datapath mux selects, FSM states and the instruction classifier.
package ctrl_encode_def;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  localparam logic [1:0] ASEL_PC     = 2'b00;
  localparam logic [1:0] ASEL_RS     = 2'b01;
  localparam logic [1:0] ASEL_SHAMT  = 2'b10;
  localparam logic [1:0] BSEL_RT     = 2'b00;
  localparam logic [1:0] BSEL_FOUR   = 2'b01;
  localparam logic [1:0] BSEL_IMM    = 2'b10;
  localparam logic [1:0] BSEL_BRANCH = 2'b11;
  localparam logic [1:0] NPC_ALU     = 2'b00;
  localparam logic [1:0] NPC_ALUOUT  = 2'b01;
  localparam logic [1:0] NPC_JUMP    = 2'b10;
  localparam logic [1:0] NPC_RS      = 2'b11;
  localparam logic [1:0] GPR_RD      = 2'b00;
  localparam logic [1:0] GPR_RT      = 2'b01;
  localparam logic [1:0] GPR_RA      = 2'b10;
  localparam logic [1:0] WD_ALUOUT   = 2'b00;
  localparam logic [1:0] WD_MDR      = 2'b01;
  localparam logic [1:0] WD_PC       = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_RALU,
    CLS_RSHIFT,
    CLS_JR,
    CLS_IALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_ILLEGAL
  } instClass_e;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       regWrite;
    logic       memWrite;
    logic       iord;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       extOp;
    logic [3:0] aluOp;
    logic [1:0] npcSel;
    logic [1:0] gprSel;
    logic [1:0] wdSel;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  // Anything not listed here is unsupported and must surface as illegal in DECODE.
  function automatic instClass_e classify(input logic [5:0] op, input logic [5:0] funct);
    instClass_e cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND,
          FUNCT_OR, FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU: cls = CLS_RALU;
          FUNCT_SLL, FUNCT_SRL:                       cls = CLS_RSHIFT;
          FUNCT_JR:                                   cls = CLS_JR;
          default:                                    cls = CLS_ILLEGAL;
        endcase
      end
      OP_J:                                 cls = CLS_J;
      OP_JAL:                               cls = CLS_JAL;
      OP_BEQ:                               cls = CLS_BEQ;
      OP_BNE:                               cls = CLS_BNE;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:    cls = CLS_IALU;
      OP_LW:                                cls = CLS_LW;
      OP_SW:                                cls = CLS_SW;
      default:                              cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational op/funct decoder producing the ALU opcode and immediate
// extension mode; shared with the single-cycle CPU.
module alu_dec
  import ctrl_encode_def::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       ext_op_o
);

  // Logical immediates zero-extend; everything else sign-extends.
  always_comb begin
    alu_op_o = ALU_NOP;
    ext_op_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: alu_op_o = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_op_o = ALU_SUB;
          FUNCT_AND:             alu_op_o = ALU_AND;
          FUNCT_OR:              alu_op_o = ALU_OR;
          FUNCT_NOR:             alu_op_o = ALU_NOR;
          FUNCT_SLT:             alu_op_o = ALU_SLT;
          FUNCT_SLTU:            alu_op_o = ALU_SLTU;
          FUNCT_SLL:             alu_op_o = ALU_SLL;
          FUNCT_SRL:             alu_op_o = ALU_SRL;
          default:               alu_op_o = ALU_NOP;
        endcase
      end
      OP_ADDI:        alu_op_o = ALU_ADD;
      OP_SLTI:        alu_op_o = ALU_SLT;
      OP_ANDI: begin
        alu_op_o = ALU_AND;
        ext_op_o = 1'b1;
      end
      OP_ORI: begin
        alu_op_o = ALU_OR;
        ext_op_o = 1'b1;
      end
      OP_LW, OP_SW:   alu_op_o = ALU_ADD;
      OP_BEQ, OP_BNE: alu_op_o = ALU_SUB;
      default:        alu_op_o = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB and drives
// the shared ALU, operand muxes and every architectural write enable.
module mc_ctrl
  import ctrl_encode_def::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       iord,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [3:0] alu_op,
  output logic [1:0] npc_sel,
  output logic [1:0] gpr_sel,
  output logic [1:0] wd_sel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  instClass_e cls;
  logic [3:0] decAluOp;
  logic       decExtOp;
  ctrl_t      ctrl, outCtrl;

  assign cls = classify(op, funct);

  alu_dec uAluDec (
    .op_i     (op),
    .funct_i  (funct),
    .alu_op_o (decAluOp),
    .ext_op_o (decExtOp)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: begin
        ctrl.irWrite = 1'b1;
        ctrl.pcWrite = 1'b1;
        ctrl.aluSrcA = ASEL_PC;
        ctrl.aluSrcB = BSEL_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.npcSel  = NPC_ALU;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        // Branch target is computed here unconditionally so EXE can load it from ALUOut.
        ctrl.aluSrcA = ASEL_PC;
        ctrl.aluSrcB = BSEL_BRANCH;
        ctrl.aluOp   = ALU_ADD;
        state_d      = ST_EXE;
        case (cls)
          CLS_J, CLS_JAL: begin
            ctrl.pcWrite = 1'b1;
            ctrl.npcSel  = NPC_JUMP;
            ctrl.retire  = 1'b1;
            state_d      = ST_FETCH;
            if (cls == CLS_JAL) begin
              ctrl.regWrite = 1'b1;
              ctrl.gprSel   = GPR_RA;
              ctrl.wdSel    = WD_PC;
            end
          end
          CLS_JR: begin
            ctrl.pcWrite = 1'b1;
            ctrl.npcSel  = NPC_RS;
            ctrl.retire  = 1'b1;
            state_d      = ST_FETCH;
          end
          CLS_ILLEGAL: begin
            ctrl.illegal = 1'b1;
            if (ILLEGAL_TRAP) begin
              state_d = ST_HALT;
            end else begin
              ctrl.retire = 1'b1;
              state_d     = ST_FETCH;
            end
          end
          default: state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        ctrl.aluSrcA = ASEL_RS;
        ctrl.aluOp   = decAluOp;
        ctrl.extOp   = decExtOp;
        case (cls)
          CLS_RALU: begin
            ctrl.aluSrcB = BSEL_RT;
            state_d      = ST_WB;
          end
          CLS_RSHIFT: begin
            ctrl.aluSrcA = ASEL_SHAMT;
            ctrl.aluSrcB = BSEL_RT;
            state_d      = ST_WB;
          end
          CLS_IALU: begin
            ctrl.aluSrcB = BSEL_IMM;
            state_d      = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            ctrl.aluSrcB = BSEL_IMM;
            state_d      = ST_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            // Mealy: the branch decision follows the Zero flag in this same cycle.
            ctrl.aluSrcB = BSEL_RT;
            ctrl.npcSel  = NPC_ALUOUT;
            ctrl.pcWrite = (cls == CLS_BEQ) ? zero : ~zero;
            ctrl.retire  = 1'b1;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        ctrl.iord = 1'b1;
        if (cls == CLS_SW) begin
          ctrl.memWrite = 1'b1;
          ctrl.retire   = 1'b1;
          state_d       = ST_FETCH;
        end else if (cls == CLS_LW) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.retire   = 1'b1;
        ctrl.gprSel   = (cls == CLS_RALU || cls == CLS_RSHIFT) ? GPR_RD : GPR_RT;
        ctrl.wdSel    = (cls == CLS_LW) ? WD_MDR : WD_ALUOUT;
        state_d       = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // The reset state is FETCH, so outputs are masked to keep every enable low while rstn is held.
  assign outCtrl   = rstn ? ctrl : '0;

  assign pc_write  = outCtrl.pcWrite;
  assign ir_write  = outCtrl.irWrite;
  assign reg_write = outCtrl.regWrite;
  assign mem_write = outCtrl.memWrite;
  assign iord      = outCtrl.iord;
  assign alu_src_a = outCtrl.aluSrcA;
  assign alu_src_b = outCtrl.aluSrcB;
  assign ext_op    = outCtrl.extOp;
  assign alu_op    = outCtrl.aluOp;
  assign npc_sel   = outCtrl.npcSel;
  assign gpr_sel   = outCtrl.gprSel;
  assign wd_sel    = outCtrl.wdSel;
  assign retire    = outCtrl.retire;
  assign illegal   = outCtrl.illegal;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: both trap settings run side by side
// and every cycle's full output word is compared against a hand-built vector.
module tb_mc_ctrl;

  localparam logic [5:0] OPR  = 6'b000000;
  localparam logic [5:0] OPJ  = 6'b000010;
  localparam logic [5:0] OPJL = 6'b000011;
  localparam logic [5:0] OPBQ = 6'b000100;
  localparam logic [5:0] OPBN = 6'b000101;
  localparam logic [5:0] OPSI = 6'b001010;
  localparam logic [5:0] OPOR = 6'b001101;
  localparam logic [5:0] OPLW = 6'b100011;
  localparam logic [5:0] OPSW = 6'b101011;
  localparam logic [5:0] OPXX = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FSUB = 6'b100010;
  localparam logic [5:0] FNOR = 6'b100111;
  localparam logic [5:0] FSLL = 6'b000000;
  localparam logic [5:0] FJR  = 6'b001000;
  localparam logic [5:0] F0   = 6'b000000;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] op, funct;
  logic       zero;

  logic       pcWriteT, irWriteT, regWriteT, memWriteT, iordT, extOpT, retireT, illegalT;
  logic [1:0] aluSrcAT, aluSrcBT, npcSelT, gprSelT, wdSelT;
  logic [3:0] aluOpT;
  logic [2:0] stateT;
  logic       pcWriteN, irWriteN, regWriteN, memWriteN, iordN, extOpN, retireN, illegalN;
  logic [1:0] aluSrcAN, aluSrcBN, npcSelN, gprSelN, wdSelN;
  logic [3:0] aluOpN;
  logic [2:0] stateN;

  logic [24:0] vecT, vecN;
  logic [24:0] vF, vD, vRst, vHalt, vRWb, vIWb, vLwExe;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dutTrap (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
    .pc_write(pcWriteT), .ir_write(irWriteT), .reg_write(regWriteT), .mem_write(memWriteT),
    .iord(iordT), .alu_src_a(aluSrcAT), .alu_src_b(aluSrcBT), .ext_op(extOpT),
    .alu_op(aluOpT), .npc_sel(npcSelT), .gpr_sel(gprSelT), .wd_sel(wdSelT),
    .retire(retireT), .illegal(illegalT), .state(stateT)
  );

  mc_ctrl #(.ILLEGAL_TRAP(1'b0)) dutNop (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
    .pc_write(pcWriteN), .ir_write(irWriteN), .reg_write(regWriteN), .mem_write(memWriteN),
    .iord(iordN), .alu_src_a(aluSrcAN), .alu_src_b(aluSrcBN), .ext_op(extOpN),
    .alu_op(aluOpN), .npc_sel(npcSelN), .gpr_sel(gprSelN), .wd_sel(wdSelN),
    .retire(retireN), .illegal(illegalN), .state(stateN)
  );

  assign vecT = {pcWriteT, irWriteT, regWriteT, memWriteT, iordT, aluSrcAT, aluSrcBT, extOpT,
                 aluOpT, npcSelT, gprSelT, wdSelT, retireT, illegalT, stateT};
  assign vecN = {pcWriteN, irWriteN, regWriteN, memWriteN, iordN, aluSrcAN, aluSrcBN, extOpN,
                 aluOpN, npcSelN, gprSelN, wdSelN, retireN, illegalN, stateN};

  // Field order: pcw irw rw mw iord srcA srcB ext aluop npc gpr wd retire illegal state
  function automatic logic [24:0] ev(input int pcw, input int irw, input int rw, input int mw,
                                     input int io, input int a, input int b, input int ext,
                                     input int alu, input int npc, input int gpr, input int wd,
                                     input int ret, input int ill, input int st);
    return {1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(io), 2'(a), 2'(b), 1'(ext),
            4'(alu), 2'(npc), 2'(gpr), 2'(wd), 1'(ret), 1'(ill), 3'(st)};
  endfunction

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
    @(negedge clk);
    op    = o;
    funct = f;
    zero  = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [24:0] actual, input logic [24:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %07h expected %07h", tag, actual, expected);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [24:0] expected);
    applyStimulus(o, f, z);
    checkOutput(tag, vecT, expected);
  endtask

  initial begin
    rstn  = 1'b0;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    vRst   = '0;
    vF     = ev(1,1,0,0,0, 0,1,0,1, 0,0,0, 0,0,0);
    vD     = ev(0,0,0,0,0, 0,3,0,1, 0,0,0, 0,0,1);
    vHalt  = ev(0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,5);
    vRWb   = ev(0,0,1,0,0, 0,0,0,0, 0,0,0, 1,0,4);
    vIWb   = ev(0,0,1,0,0, 0,0,0,0, 0,1,0, 1,0,4);
    vLwExe = ev(0,0,0,0,0, 1,2,0,1, 0,0,0, 0,0,2);

    applyStimulus(OPLW, F0, 1'b0);
    checkOutput("rst_trap", vecT, vRst);
    checkOutput("rst_nop", vecN, vRst);
    rstn = 1'b1;
    #1;
    checkOutput("lw0_fetch", vecT, vF);
    step("lw0_dec", OPLW, F0, 1'b0, vD);
    step("lw0_exe", OPLW, F0, 1'b0, vLwExe);

    // Abort the lw mid-EXE and hold reset for three cycles.
    rstn = 1'b0;
    #1;
    checkOutput("midrst0", vecT, vRst);
    step("midrst1", OPLW, F0, 1'b0, vRst);
    step("midrst2", OPLW, F0, 1'b0, vRst);
    checkOutput("midrst2_nop", vecN, vRst);
    applyStimulus(OPR, FADD, 1'b0);
    rstn = 1'b1;
    #1;
    checkOutput("rel_fetch", vecT, vF);

    step("add_dec", OPR, FADD, 1'b0, vD);
    step("add_exe", OPR, FADD, 1'b0, ev(0,0,0,0,0, 1,0,0,1, 0,0,0, 0,0,2));
    step("add_wb",  OPR, FADD, 1'b0, vRWb);
    step("sub_fetch", OPR, FSUB, 1'b0, vF);
    step("sub_dec", OPR, FSUB, 1'b0, vD);
    step("sub_exe", OPR, FSUB, 1'b0, ev(0,0,0,0,0, 1,0,0,2, 0,0,0, 0,0,2));
    step("sub_wb",  OPR, FSUB, 1'b0, vRWb);
    step("nor_fetch", OPR, FNOR, 1'b0, vF);
    step("nor_dec", OPR, FNOR, 1'b0, vD);
    step("nor_exe", OPR, FNOR, 1'b0, ev(0,0,0,0,0, 1,0,0,8, 0,0,0, 0,0,2));
    step("nor_wb",  OPR, FNOR, 1'b0, vRWb);
    step("sll_fetch", OPR, FSLL, 1'b0, vF);
    step("sll_dec", OPR, FSLL, 1'b0, vD);
    step("sll_exe", OPR, FSLL, 1'b0, ev(0,0,0,0,0, 2,0,0,7, 0,0,0, 0,0,2));
    step("sll_wb",  OPR, FSLL, 1'b0, vRWb);

    step("ori_fetch", OPOR, F0, 1'b0, vF);
    step("ori_dec", OPOR, F0, 1'b0, vD);
    step("ori_exe", OPOR, F0, 1'b0, ev(0,0,0,0,0, 1,2,1,4, 0,0,0, 0,0,2));
    step("ori_wb",  OPOR, F0, 1'b0, vIWb);
    step("slti_fetch", OPSI, F0, 1'b0, vF);
    step("slti_dec", OPSI, F0, 1'b0, vD);
    step("slti_exe", OPSI, F0, 1'b0, ev(0,0,0,0,0, 1,2,0,5, 0,0,0, 0,0,2));
    step("slti_wb",  OPSI, F0, 1'b0, vIWb);

    step("beq1_fetch", OPBQ, F0, 1'b0, vF);
    step("beq1_dec", OPBQ, F0, 1'b0, vD);
    step("beq1_exe", OPBQ, F0, 1'b1, ev(1,0,0,0,0, 1,0,0,2, 1,0,0, 1,0,2));
    zero = 1'b0;
    #1;
    checkOutput("beq_mealy", vecT, ev(0,0,0,0,0, 1,0,0,2, 1,0,0, 1,0,2));
    step("beq0_fetch", OPBQ, F0, 1'b0, vF);
    step("beq0_dec", OPBQ, F0, 1'b0, vD);
    step("beq0_exe", OPBQ, F0, 1'b0, ev(0,0,0,0,0, 1,0,0,2, 1,0,0, 1,0,2));
    step("bne1_fetch", OPBN, F0, 1'b1, vF);
    step("bne1_dec", OPBN, F0, 1'b1, vD);
    step("bne1_exe", OPBN, F0, 1'b1, ev(0,0,0,0,0, 1,0,0,2, 1,0,0, 1,0,2));
    step("bne0_fetch", OPBN, F0, 1'b0, vF);
    step("bne0_dec", OPBN, F0, 1'b0, vD);
    step("bne0_exe", OPBN, F0, 1'b0, ev(1,0,0,0,0, 1,0,0,2, 1,0,0, 1,0,2));

    step("lw_fetch", OPLW, F0, 1'b0, vF);
    step("lw_dec", OPLW, F0, 1'b0, vD);
    step("lw_exe", OPLW, F0, 1'b0, vLwExe);
    step("lw_mem", OPLW, F0, 1'b0, ev(0,0,0,0,1, 0,0,0,0, 0,0,0, 0,0,3));
    step("lw_wb",  OPLW, F0, 1'b0, ev(0,0,1,0,0, 0,0,0,0, 0,1,1, 1,0,4));
    step("sw_fetch", OPSW, F0, 1'b0, vF);
    step("sw_dec", OPSW, F0, 1'b0, vD);
    step("sw_exe", OPSW, F0, 1'b0, vLwExe);
    step("sw_mem", OPSW, F0, 1'b0, ev(0,0,0,1,1, 0,0,0,0, 0,0,0, 1,0,3));

    step("jal_fetch", OPJL, F0, 1'b0, vF);
    step("jal_dec", OPJL, F0, 1'b0, ev(1,0,1,0,0, 0,3,0,1, 2,2,2, 1,0,1));
    step("j_fetch", OPJ, F0, 1'b0, vF);
    step("j_dec", OPJ, F0, 1'b0, ev(1,0,0,0,0, 0,3,0,1, 2,0,0, 1,0,1));
    step("jr_fetch", OPR, FJR, 1'b0, vF);
    step("jr_dec", OPR, FJR, 1'b0, ev(1,0,0,0,0, 0,3,0,1, 3,0,0, 1,0,1));

    step("ill_fetch", OPXX, F0, 1'b0, vF);
    applyStimulus(OPXX, F0, 1'b0);
    checkOutput("ill_dec_trap", vecT, ev(0,0,0,0,0, 0,3,0,1, 0,0,0, 0,1,1));
    checkOutput("ill_dec_nop", vecN, ev(0,0,0,0,0, 0,3,0,1, 0,0,0, 1,1,1));
    applyStimulus(OPR, FADD, 1'b0);
    checkOutput("halt0", vecT, vHalt);
    checkOutput("nop_refetch", vecN, vF);
    for (int i = 0; i < 3; i++) step("halt_hold", OPR, FADD, 1'b1, vHalt);

    applyStimulus(OPR, FADD, 1'b0);
    rstn = 1'b0;
    #1;
    checkOutput("halt_rst", vecT, vRst);
    applyStimulus(OPR, FADD, 1'b0);
    rstn = 1'b1;
    #1;
    checkOutput("halt_exit", vecT, vF);
    step("post_dec", OPR, FADD, 1'b0, vD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
